// File: rtl/rx_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module   : rx_ctl_if
//  Purpose  : Serial line, oversampling tick and byte handshake for rx_ctl.
//  Revision : 1.0  initial release
// ============================================================================
interface rx_ctl_if #(
    parameter int DATA_BITS = 8
);
    logic                 bclk;
    logic                 rx;
    logic                 rd;
    logic [DATA_BITS-1:0] dout;
    logic                 dout_rdy;
    logic                 frame_err;
    logic                 overrun;
    logic                 rx_busy;

    modport master (
        output bclk, rx, rd,
        input  dout, dout_rdy, frame_err, overrun, rx_busy
    );

    modport slave (
        input  bclk, rx, rd,
        output dout, dout_rdy, frame_err, overrun, rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/rx_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : rx_ctl
//  Purpose  : UART receiver, oversampled 3-vote mid-bit sampling, LSB first,
//             single-entry holding register with framing/overrun flags.
//  Revision : 1.0  initial release
// ============================================================================
module rx_ctl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    rx_ctl_if.slave   bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] c_tick_max = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] c_vote_lo  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] c_vote_mid = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] c_vote_hi  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] c_last_bit = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_rx_meta, r_rx_s;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_vote_a, r_vote_b;
    logic                 r_dout_rdy, r_frame_err, r_overrun;

    logic w_start_det, w_decide, w_maj;
    logic w_shift_en, w_bit_clr, w_byte_done, w_fe_set;

    assign w_start_det = bus.bclk && (r_state == S_IDLE) && !r_rx_s;
    assign w_decide    = bus.bclk && (r_tick == c_vote_hi);
    assign w_maj       = (r_vote_a & r_vote_b) | (r_vote_a & r_rx_s) | (r_vote_b & r_rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_bit_clr   = 1'b0;
        w_byte_done = 1'b0;
        w_fe_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_det) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_decide) begin
                    if (w_maj) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_bit_clr   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_decide) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_last_bit) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_decide) begin
                    if (w_maj) begin
                        w_byte_done = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_fe_set    = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (bus.bclk && r_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tick phase restarts on the start edge so the votes land mid-bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick    <= '0;
            r_vote_a  <= 1'b1;
            r_vote_b  <= 1'b1;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (bus.bclk) begin
            if (w_start_det)               r_tick <= '0;
            else if (r_tick == c_tick_max) r_tick <= '0;
            else                           r_tick <= r_tick + 1'b1;
            if (r_tick == c_vote_lo)  r_vote_a <= r_rx_s;
            if (r_tick == c_vote_mid) r_vote_b <= r_rx_s;
            if (w_bit_clr)       r_bit_cnt <= '0;
            else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift_en) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout      <= '0;
            r_dout_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_byte_done) begin
                r_dout     <= r_shift;
                r_dout_rdy <= 1'b1;
            end else if (bus.rd) begin
                r_dout_rdy <= 1'b0;
            end
            if (w_byte_done && r_dout_rdy && !bus.rd) r_overrun <= 1'b1;
            else if (bus.rd)                          r_overrun <= 1'b0;
            if (w_fe_set)    r_frame_err <= 1'b1;
            else if (bus.rd) r_frame_err <= 1'b0;
        end
    end

    assign bus.dout      = r_dout;
    assign bus.dout_rdy  = r_dout_rdy;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.rx_busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire
